// File: rtl/xadac_vread_gather.sv
// -----------------------------------------------------------------------------
// xadac_vread_gather
//   Memory-side read engine for the vector-load unit. It accepts one full-width
//   vector read (id, byte address) on AR and splits it into NBeats word-wide
//   reads on a narrow, in-order memory port. Up to MaxOutstanding word reads
//   may be in flight at once. The returned words are assembled (word 0 in the
//   LSBs) into one VecDataWidth beat, which is returned on R with the
//   originating id. Only one vector request is handled at a time.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   ar_id/addr/valid     vector request in, ar_ready out (high only in IDLE)
//   r_id/data/valid      assembled vector out, r_ready in
//   mem_req_valid/addr   word read request out, mem_req_ready in
//   mem_rsp_valid/data   in-order word read data in (no backpressure)
// -----------------------------------------------------------------------------
module xadac_vread_gather #(
    parameter int AddrWidth      = 32,
    parameter int IdWidth        = 3,
    parameter int VecDataWidth   = 128,
    parameter int WordWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [IdWidth-1:0]      ar_id,
    input  logic [AddrWidth-1:0]    ar_addr,
    input  logic                    ar_valid,
    output logic                    ar_ready,
    output logic [IdWidth-1:0]      r_id,
    output logic [VecDataWidth-1:0] r_data,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [AddrWidth-1:0]    mem_req_addr,
    input  logic                    mem_rsp_valid,
    input  logic [WordWidth-1:0]    mem_rsp_data
);

    localparam int NBeats  = VecDataWidth / WordWidth;
    localparam int ByteOff = $clog2(WordWidth / 8);
    localparam int CntW    = $clog2(NBeats + 1);

    localparam logic [CntW-1:0] NBeatsC  = CntW'(NBeats);
    localparam logic [CntW-1:0] LastIdxC = CntW'(NBeats - 1);
    localparam logic [CntW-1:0] MaxOutC  = CntW'(MaxOutstanding);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [IdWidth-1:0]      r_lat_id;
    logic [IdWidth-1:0]      r_rid;
    logic [AddrWidth-1:0]    r_base;
    logic [CntW-1:0]         r_iss;
    logic [CntW-1:0]         r_rcv;
    logic [VecDataWidth-1:0] r_buf;
    logic [VecDataWidth-1:0] r_rdata;
    logic                    r_rvalid;

    logic [VecDataWidth-1:0] w_buf_nxt;
    logic [CntW-1:0]         w_outstanding;
    logic [AddrWidth-1:0]    w_base_aligned;
    logic                    w_ar_fire;
    logic                    w_can_issue;
    logic                    w_req_fire;
    logic                    w_rsp_take;
    logic                    w_last;

    // Handshake decode and issue/capture qualifiers from registered state.
    always_comb begin
        w_outstanding  = r_iss - r_rcv;
        // Issue limit uses the counters before this cycle's updates.
        w_can_issue    = (r_state == ST_FETCH) && (r_iss < NBeatsC) &&
                         (w_outstanding < MaxOutC);
        w_ar_fire      = (r_state == ST_IDLE) && ar_valid;
        w_req_fire     = w_can_issue && mem_req_ready;
        // A response with nothing outstanding is a protocol violation; drop it.
        w_rsp_take     = (r_state == ST_FETCH) && mem_rsp_valid && (r_rcv != r_iss);
        w_last         = w_rsp_take && (r_rcv == LastIdxC);
        w_base_aligned = (ar_addr >> ByteOff) << ByteOff;
    end

    // Assembly buffer with the incoming word merged into slot r_rcv.
    always_comb begin
        w_buf_nxt = r_buf;
        for (int w = 0; w < NBeats; w++) begin
            if (w_rsp_take && (r_rcv == CntW'(w))) begin
                w_buf_nxt[w*WordWidth +: WordWidth] = mem_rsp_data;
            end else begin
                w_buf_nxt[w*WordWidth +: WordWidth] = r_buf[w*WordWidth +: WordWidth];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ar_fire) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (w_last) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_RESP: begin
                if (r_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; memory request is a function of registered state only.
    always_comb begin
        ar_ready      = (r_state == ST_IDLE);
        mem_req_valid = w_can_issue;
        // Address arithmetic wraps modulo 2^AddrWidth by construction.
        mem_req_addr  = r_base + (AddrWidth'(r_iss) << ByteOff);
    end

    // Request context, counters, assembly buffer and R channel registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lat_id <= {IdWidth{1'b0}};
            r_rid    <= {IdWidth{1'b0}};
            r_base   <= {AddrWidth{1'b0}};
            r_iss    <= {CntW{1'b0}};
            r_rcv    <= {CntW{1'b0}};
            r_buf    <= {VecDataWidth{1'b0}};
            r_rdata  <= {VecDataWidth{1'b0}};
            r_rvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ar_fire) begin
                        r_lat_id <= ar_id;
                        r_base   <= w_base_aligned;
                        r_iss    <= {CntW{1'b0}};
                        r_rcv    <= {CntW{1'b0}};
                        r_buf    <= {VecDataWidth{1'b0}};
                    end
                end
                ST_FETCH: begin
                    if (w_req_fire) begin
                        r_iss <= r_iss + CntW'(1);
                    end
                    if (w_rsp_take) begin
                        r_rcv <= r_rcv + CntW'(1);
                        r_buf <= w_buf_nxt;
                    end
                    if (w_last) begin
                        r_rdata  <= w_buf_nxt;
                        r_rid    <= r_lat_id;
                        r_rvalid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (r_ready) begin
                        r_rvalid <= 1'b0;
                    end
                end
                default: begin
                    r_rvalid <= 1'b0;
                end
            endcase
        end
    end

    assign r_id    = r_rid;
    assign r_data  = r_rdata;
    assign r_valid = r_rvalid;

    xadac_vread_gather_chk #(
        .CntW (CntW)
    ) u_chk (
        .clk           (clk),
        .rstn          (rstn),
        .i_fetch       (r_state == ST_FETCH),
        .i_rsp_valid   (mem_rsp_valid),
        .i_iss         (r_iss),
        .i_rcv         (r_rcv)
    );

endmodule

// -----------------------------------------------------------------------------
// xadac_vread_gather_chk
//   Protocol checker: memory must not return data while nothing is outstanding.
//   Ports: clk, rstn, i_fetch (engine in FETCH), i_rsp_valid, i_iss, i_rcv.
// -----------------------------------------------------------------------------
module xadac_vread_gather_chk #(
    parameter int CntW = 3
) (
    input logic            clk,
    input logic            rstn,
    input logic            i_fetch,
    input logic            i_rsp_valid,
    input logic [CntW-1:0] i_iss,
    input logic [CntW-1:0] i_rcv
);

    a_no_unsolicited_rsp: assert property (
        @(posedge clk) disable iff (!rstn)
        (i_fetch && i_rsp_valid) |-> (i_iss != i_rcv)
    );

endmodule

// File: tb/tb_xadac_vread_gather.sv
module tb_xadac_vread_gather;

    logic         clk = 1'b0;
    logic         rstn;

    logic [2:0]   ar_id;
    logic [31:0]  ar_addr;
    logic         ar_valid;
    logic         ar_ready;
    logic [2:0]   r_id;
    logic [127:0] r_data;
    logic         r_valid;
    logic         r_ready;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;

    logic [2:0]   b_ar_id;
    logic [31:0]  b_ar_addr;
    logic         b_ar_valid;
    logic         b_ar_ready;
    logic [2:0]   b_r_id;
    logic [127:0] b_r_data;
    logic         b_r_valid;
    logic         b_r_ready;
    logic         b_mem_req_valid;
    logic         b_mem_req_ready;
    logic [31:0]  b_mem_req_addr;
    logic         b_mem_rsp_valid;
    logic [31:0]  b_mem_rsp_data;

    int           n_checks = 0;
    int           n_err    = 0;
    logic [31:0]  rsp_base;
    int           rsp_idx;
    logic [31:0]  b_rsp_base;
    int           b_rsp_idx;
    logic [31:0]  addr_log [16];
    int           n_log;
    int           b_outst;
    int           b_max_outst;
    int           k;

    always #5 clk = ~clk;

    xadac_vread_gather u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .ar_id         (ar_id),
        .ar_addr       (ar_addr),
        .ar_valid      (ar_valid),
        .ar_ready      (ar_ready),
        .r_id          (r_id),
        .r_data        (r_data),
        .r_valid       (r_valid),
        .r_ready       (r_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    xadac_vread_gather #(.MaxOutstanding(1)) u_dut1 (
        .clk           (clk),
        .rstn          (rstn),
        .ar_id         (b_ar_id),
        .ar_addr       (b_ar_addr),
        .ar_valid      (b_ar_valid),
        .ar_ready      (b_ar_ready),
        .r_id          (b_r_id),
        .r_data        (b_r_data),
        .r_valid       (b_r_valid),
        .r_ready       (b_r_ready),
        .mem_req_valid (b_mem_req_valid),
        .mem_req_ready (b_mem_req_ready),
        .mem_req_addr  (b_mem_req_addr),
        .mem_rsp_valid (b_mem_rsp_valid),
        .mem_rsp_data  (b_mem_rsp_data)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle; both memory models answer one cycle after each request.
    task automatic tick();
        logic f;
        logic bf;
        f  = mem_req_valid && mem_req_ready;
        bf = b_mem_req_valid && b_mem_req_ready;
        if (f && n_log < 16) begin
            addr_log[n_log] = mem_req_addr;
            n_log++;
        end
        b_outst = b_outst + (bf ? 1 : 0) - (b_mem_rsp_valid ? 1 : 0);
        if (b_outst > b_max_outst) b_max_outst = b_outst;
        @(posedge clk);
        #1;
        mem_rsp_valid = f;
        mem_rsp_data  = f ? rsp_base + 32'(rsp_idx) : 32'h0;
        if (f) rsp_idx++;
        b_mem_rsp_valid = bf;
        b_mem_rsp_data  = bf ? b_rsp_base + 32'(b_rsp_idx) : 32'h0;
        if (bf) b_rsp_idx++;
    endtask

    task automatic wait_r(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!r_valid && cnt < 40);
    endtask

    task automatic send_ar(input logic [2:0] id, input logic [31:0] addr,
                           input logic [31:0] base, input logic [31:0] a0);
        check("ar_ready_idle", ar_ready, 1'b1);
        ar_id    = id;
        ar_addr  = addr;
        ar_valid = 1'b1;
        rsp_base = base;
        rsp_idx  = 0;
        n_log    = 0;
        tick();
        ar_valid = 1'b0;
        check("req_valid_first", mem_req_valid, 1'b1);
        check("req_addr_first", mem_req_addr, a0);
    endtask

    task automatic run_vec(input logic [2:0] id, input logic [31:0] addr, input logic [31:0] base,
                           input logic [127:0] exp_data, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] exp_a [4];
        int cnt;
        exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2; exp_a[3] = a3;
        send_ar(id, addr, base, a0);
        wait_r(cnt);
        check("r_valid_latency", 32'(cnt + 1), 32'd6);
        check("r_id", r_id, id);
        check("r_data", r_data, exp_data);
        check("n_mem_reqs", 32'(n_log), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("mem_addr%0d", i), addr_log[i], exp_a[i]);
        tick();
        check("r_valid_drop", r_valid, 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        ar_id = 3'd0; ar_addr = 32'h0; ar_valid = 1'b0; r_ready = 1'b1;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        b_ar_id = 3'd0; b_ar_addr = 32'h0; b_ar_valid = 1'b0; b_r_ready = 1'b1;
        b_mem_req_ready = 1'b1; b_mem_rsp_valid = 1'b0; b_mem_rsp_data = 32'h0;
        rsp_base = 32'h0; rsp_idx = 0; b_rsp_base = 32'h0; b_rsp_idx = 0;
        n_log = 0; b_outst = 0; b_max_outst = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ar_ready", ar_ready, 1'b1);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_r_id", r_id, 3'd0);
        check("rst_r_data", r_data, 128'h0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, 32'h0);
        rstn = 1'b1;
        tick();

        // Basic aligned vector.
        run_vec(3'd5, 32'h0000_1000, 32'hA0, 128'h000000A3_000000A2_000000A1_000000A0,
                32'h1000, 32'h1004, 32'h1008, 32'h100C);
        // Unaligned base address is rounded down to a word.
        run_vec(3'd1, 32'h0000_2006, 32'h10, 128'h00000013_00000012_00000011_00000010,
                32'h2004, 32'h2008, 32'h200C, 32'h2010);
        // Address wrap past the top of the address space.
        run_vec(3'd7, 32'hFFFF_FFF8, 32'h20, 128'h00000023_00000022_00000021_00000020,
                32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004);

        // R backpressure with a pending AR.
        r_ready = 1'b0;
        send_ar(3'd2, 32'h0000_3000, 32'h30, 32'h3000);
        wait_r(k);
        check("resp_reached", r_valid, 1'b1);
        ar_id = 3'd6; ar_addr = 32'h0000_4000; ar_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("resp_ar_ready_low", ar_ready, 1'b0);
            check("resp_r_valid_held", r_valid, 1'b1);
            check("resp_r_data_stable", r_data, 128'h00000033_00000032_00000031_00000030);
            check("resp_r_id_stable", r_id, 3'd2);
            tick();
        end
        check("resp_ar_ready_low_last", ar_ready, 1'b0);
        r_ready = 1'b1;
        rsp_base = 32'h40; rsp_idx = 0; n_log = 0;
        tick();
        check("after_r_hs_ar_ready", ar_ready, 1'b1);
        check("after_r_hs_r_valid", r_valid, 1'b0);
        tick();
        ar_valid = 1'b0;
        check("second_req_valid", mem_req_valid, 1'b1);
        check("second_req_addr", mem_req_addr, 32'h4000);
        wait_r(k);
        check("second_r_valid", r_valid, 1'b1);
        check("second_r_id", r_id, 3'd6);
        check("second_r_data", r_data, 128'h00000043_00000042_00000041_00000040);
        tick();

        // Reset in the middle of FETCH after two words have been captured.
        send_ar(3'd4, 32'h0000_5000, 32'h50, 32'h5000);
        repeat (3) tick();
        rstn = 1'b0;
        #1;
        check("midrst_ar_ready", ar_ready, 1'b1);
        check("midrst_r_valid", r_valid, 1'b0);
        check("midrst_mem_req_valid", mem_req_valid, 1'b0);
        check("midrst_mem_req_addr", mem_req_addr, 32'h0);
        check("midrst_r_data", r_data, 128'h0);
        mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        repeat (3) tick();
        check("stray_r_valid", r_valid, 1'b0);
        check("stray_ar_ready", ar_ready, 1'b1);
        check("stray_mem_req_valid", mem_req_valid, 1'b0);
        run_vec(3'd3, 32'h0000_6000, 32'h60, 128'h00000063_00000062_00000061_00000060,
                32'h6000, 32'h6004, 32'h6008, 32'h600C);

        // MaxOutstanding=1 instance with memory stalled after the first request.
        b_ar_id = 3'd4; b_ar_addr = 32'h0000_7000; b_ar_valid = 1'b1;
        b_rsp_base = 32'hC0; b_rsp_idx = 0; b_outst = 0; b_max_outst = 0;
        tick();
        b_ar_valid = 1'b0;
        check("b_req_valid_first", b_mem_req_valid, 1'b1);
        check("b_req_addr_first", b_mem_req_addr, 32'h7000);
        tick();
        check("b_one_outstanding", b_mem_req_valid, 1'b0);
        b_mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_stall_valid", b_mem_req_valid, 1'b1);
            check("b_stall_addr", b_mem_req_addr, 32'h7004);
        end
        b_mem_req_ready = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!b_r_valid && k < 40);
        check("b_r_valid", b_r_valid, 1'b1);
        check("b_r_id", b_r_id, 3'd4);
        check("b_r_data", b_r_data, 128'h000000C3_000000C2_000000C1_000000C0);
        check("b_max_outstanding", 32'(b_max_outst), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
